// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU background-fetch definitions.
//   - nametable / attribute base constants and screen geometry
//   - fetch FSM state enum, tile bundle struct, latched per-line context
//   - calc_line_ctx(): folds scanline + Y scroll into nametable row / nt_v
package ppu_pkg;

  localparam logic [15:0] NT_BASE   = 16'h2000;
  localparam logic [15:0] AT_OFFSET = 16'h03C0;
  localparam int          NT_ROWS   = 30;
  localparam int          LINE_ROWS = 240;

  typedef enum logic [2:0] {
    ST_IDLE, ST_NT, ST_AT, ST_PLO, ST_PHI, ST_PUSH, ST_DONE
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] pt_lo;
    logic [7:0] pt_hi;
    logic [1:0] palette;
    logic [5:0] index;
  } tile_bundle_t;

  // Everything about a line that is frozen at line_start.
  typedef struct packed {
    logic [7:0] row;       // row within the selected nametable, 0..239
    logic       nt_v;      // vertical nametable select
    logic [8:0] scroll_x;  // {X nametable bit, scroll X}
    logic       pt_sel;    // background pattern table
  } line_ctx_t;

  // Scroll Y spans two stacked nametables (480 lines); wrap there, then
  // split into nametable select and row.
  function automatic line_ctx_t calc_line_ctx(input logic [8:0]  line_row,
                                              input logic [15:0] scroll,
                                              input logic [7:0]  ctrl1);
    logic [9:0] rs;
    line_ctx_t  c;
    rs = {1'b0, line_row} + {1'b0, ctrl1[1], scroll[15:8]};
    if (rs >= 10'(2 * LINE_ROWS)) rs = rs - 10'(2 * LINE_ROWS);
    c.nt_v     = (rs >= 10'(LINE_ROWS));
    c.row      = c.nt_v ? 8'(rs - 10'(LINE_ROWS)) : rs[7:0];
    c.scroll_x = {ctrl1[2], scroll[7:0]};
    c.pt_sel   = ctrl1[4];
    return c;
  endfunction

endpackage

// File: rtl/bg_tile_fetch_sequencer_if.sv
// bg_tile_fetch_sequencer_if: VRAM read port and tile loader port.
//   master: the fetch sequencer (drives req/addr and the tile bundle)
//   slave : VRAM arbiter + background shift-register loader
interface bg_tile_fetch_sequencer_if;
  logic        vram_rd_req;
  logic [15:0] vram_addr;
  logic        vram_rd_ack;
  logic [7:0]  vram_rd_data;
  logic        tile_valid;
  logic        tile_ready;
  logic [7:0]  tile_pt_lo;
  logic [7:0]  tile_pt_hi;
  logic [1:0]  tile_palette;
  logic [5:0]  tile_index;

  modport master (
    output vram_rd_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi,
           tile_palette, tile_index,
    input  vram_rd_ack, vram_rd_data, tile_ready
  );

  modport slave (
    input  vram_rd_req, vram_addr, tile_valid, tile_pt_lo, tile_pt_hi,
           tile_palette, tile_index,
    output vram_rd_ack, vram_rd_data, tile_ready
  );
endinterface

// File: rtl/bg_tile_fetch_sequencer_addr_gen.sv
// bg_addr_gen: combinational VRAM address generator for one tile.
//   ctx        in  latched line context (row, nt_v, scroll_x, pt_sel)
//   tile_index in  tile column 0..TILES_PER_LINE-1 (one past is harmless)
//   nt_byte    in  fetched nametable byte (pattern index)
//   nt_addr / at_addr / plo_addr  out  nametable, attribute, low-plane address
//   at_shift   out bit offset of this tile's 2-bit palette in the attribute byte
module bg_addr_gen
  import ppu_pkg::*;
(
  input  line_ctx_t   ctx,
  input  logic [5:0]  tile_index,
  input  logic [7:0]  nt_byte,
  output logic [15:0] nt_addr,
  output logic [15:0] at_addr,
  output logic [15:0] plo_addr,
  output logic [2:0]  at_shift
);
  logic [8:0] col;
  logic [1:0] nt_sel;

  always_comb begin
    // 9-bit add wraps at 512 so crossing into the next horizontal table is free
    col      = {tile_index, 3'b000} + ctx.scroll_x;
    nt_sel   = {ctx.nt_v, col[8]};
    nt_addr  = NT_BASE | {4'b0, nt_sel, 10'b0} | {6'b0, ctx.row[7:3], 5'b0}
             | {11'b0, col[7:3]};
    at_addr  = NT_BASE | AT_OFFSET | {4'b0, nt_sel, 10'b0}
             | {10'b0, ctx.row[7:5], 3'b0} | {13'b0, col[7:5]};
    plo_addr = {3'b0, ctx.pt_sel, nt_byte, 1'b0, ctx.row[2:0]};
    at_shift = {ctx.row[4], col[4], 1'b0};
  end
endmodule

// File: rtl/bg_tile_fetch_sequencer.sv
// bg_tile_fetch_sequencer: per-scanline background tile fetcher.
//   clk, rst_n        clock, async active-low reset
//   line_start        pulse: start a line (ignored + overrun while busy)
//   line_row, cpu_scroll_addr, ppu_ctrl1   line parameters, latched on accept
//   bus (master)      VRAM req/ack read port + tile valid/ready bundle
//   busy, line_done, overrun   line status
// Each tile: NT, AT, PLO, PHI reads then PUSH; TILES_PER_LINE tiles, then DONE.
module bg_tile_fetch_sequencer
  import ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [8:0]  line_row,
  input  logic [15:0] cpu_scroll_addr,
  input  logic [7:0]  ppu_ctrl1,
  bg_tile_fetch_sequencer_if.master bus,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);
  fetch_state_e state_q, state_d;
  line_ctx_t    ctx_q, ctx_in, gen_ctx;
  logic [5:0]   tile_index_q, gen_index;
  logic [7:0]   nt_byte_q;
  tile_bundle_t tile_q;
  logic [15:0]  addr_q, nt_addr, at_addr, plo_addr;
  logic [2:0]   at_shift;
  logic         accept, rd_hit, last_tile, push_done;
  logic         unused_ctrl_bits;

  assign unused_ctrl_bits = ^{ppu_ctrl1[7:5], ppu_ctrl1[3], ppu_ctrl1[0]};

  assign ctx_in    = calc_line_ctx(line_row, cpu_scroll_addr, ppu_ctrl1);
  assign accept    = (state_q == ST_IDLE) && line_start;
  assign rd_hit    = bus.vram_rd_req && bus.vram_rd_ack;
  assign last_tile = (tile_index_q == 6'(TILES_PER_LINE - 1));
  assign push_done = (state_q == ST_PUSH) && bus.tile_ready;

  // The address register is loaded one edge ahead of the state that uses it,
  // so the generator looks at the context/index that state will see:
  // fresh inputs when accepting a line, the next tile when leaving PUSH.
  always_comb begin
    gen_ctx   = ctx_q;
    gen_index = tile_index_q;
    if (state_q == ST_IDLE) begin
      gen_ctx   = ctx_in;
      gen_index = '0;
    end else if (state_q == ST_PUSH) begin
      gen_index = tile_index_q + 6'd1;
    end
  end

  bg_addr_gen u_addr_gen (
    .ctx        (gen_ctx),
    .tile_index (gen_index),
    .nt_byte    (nt_byte_q),
    .nt_addr    (nt_addr),
    .at_addr    (at_addr),
    .plo_addr   (plo_addr),
    .at_shift   (at_shift)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (line_start)      state_d = ST_NT;
      ST_NT:   if (rd_hit)          state_d = ST_AT;
      ST_AT:   if (rd_hit)          state_d = ST_PLO;
      ST_PLO:  if (rd_hit)          state_d = ST_PHI;
      ST_PHI:  if (rd_hit)          state_d = ST_PUSH;
      ST_PUSH: if (bus.tile_ready)  state_d = last_tile ? ST_DONE : ST_NT;
      ST_DONE:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ctx_q        <= '0;
      tile_index_q <= '0;
      nt_byte_q    <= '0;
      tile_q       <= '0;
      addr_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctx_q        <= ctx_in;
        tile_index_q <= '0;
        addr_q       <= nt_addr;
      end
      if (rd_hit) begin
        case (state_q)
          ST_NT: begin
            nt_byte_q <= bus.vram_rd_data;
            addr_q    <= at_addr;
          end
          ST_AT: begin
            tile_q.palette <= 2'(bus.vram_rd_data >> at_shift);
            addr_q         <= plo_addr;
          end
          ST_PLO: begin
            tile_q.pt_lo <= bus.vram_rd_data;
            addr_q       <= addr_q + 16'd8;  // high plane sits 8 bytes above
          end
          ST_PHI: begin
            tile_q.pt_hi <= bus.vram_rd_data;
            tile_q.index <= tile_index_q;
          end
          default: ;
        endcase
      end
      if (push_done) begin
        if (last_tile) begin
          tile_index_q <= '0;
        end else begin
          tile_index_q <= tile_index_q + 6'd1;
          addr_q       <= nt_addr;
        end
      end
    end
  end

  assign bus.vram_rd_req  = (state_q == ST_NT) || (state_q == ST_AT) ||
                            (state_q == ST_PLO) || (state_q == ST_PHI);
  assign bus.vram_addr    = addr_q;
  assign bus.tile_valid   = (state_q == ST_PUSH);
  assign bus.tile_pt_lo   = tile_q.pt_lo;
  assign bus.tile_pt_hi   = tile_q.pt_hi;
  assign bus.tile_palette = tile_q.palette;
  assign bus.tile_index   = tile_q.index;

  // DONE is not busy, but a line_start landing there is still rejected.
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign line_done = (state_q == ST_DONE);
  assign overrun   = line_start && (state_q != ST_IDLE);
endmodule

// File: tb/tb_bg_tile_fetch_sequencer.sv
module tb_bg_tile_fetch_sequencer;
  localparam int TILES = 33;

  logic        clk, rst_n, line_start;
  logic [8:0]  line_row;
  logic [15:0] scroll;
  logic [7:0]  ctrl;
  logic        busy, line_done, overrun;

  bg_tile_fetch_sequencer_if bus ();

  bg_tile_fetch_sequencer #(.TILES_PER_LINE(TILES)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_row(line_row),
    .cpu_scroll_addr(scroll), .ppu_ctrl1(ctrl), .bus(bus),
    .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int force_mem, max_delay, stall_pct, ack_wait;

  typedef struct { int lo; int hi; int pal; int idx; } exp_tile_t;
  exp_tile_t exp_tiles[$];
  int        exp_addr[$];
  int        seen_addr[$];
  int        tiles_seen, first_pal, lines_done;
  bit        active, done_due;
  bit        prev_req, prev_ack, prev_valid, prev_ready;
  logic [15:0] prev_addr;
  logic [23:0] prev_bundle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // VRAM contents: fixed NT/AT bytes for directed cases, hash otherwise.
  function automatic logic [7:0] mem(input int a);
    logic [15:0] h;
    h = 16'(a);
    if (force_mem != 0 && h[15:12] == 4'h2) return (h[9:6] == 4'hF) ? 8'hE4 : 8'h41;
    h = (h * 16'd37) ^ (h >> 7) ^ 16'h005A;
    return h[7:0];
  endfunction

  function automatic int seen_at(input int i);
    return (seen_addr.size() > i) ? seen_addr[i] : 32'hDEAD;
  endfunction

  // Reference model: the full list of reads and tiles for one line.
  task automatic build_line(input int row_in, input int sc, input int ct);
    int rs, ntv, row, col, sel, nta, ata, ntb, atb, plo;
    exp_tile_t t;
    exp_addr.delete(); exp_tiles.delete();
    rs = row_in + ((ct >> 1) & 1) * 256 + (sc >> 8);
    if (rs >= 480) rs -= 480;
    ntv = (rs >= 240) ? 1 : 0;
    row = rs - ntv * 240;
    for (int i = 0; i < TILES; i++) begin
      col = (i * 8 + ((ct >> 2) & 1) * 256 + (sc & 255)) % 512;
      sel = ntv * 2 + col / 256;
      nta = 'h2000 + sel * 1024 + (row / 8) * 32 + (col % 256) / 8;
      ata = 'h23C0 + sel * 1024 + (row / 32) * 8 + (col % 256) / 32;
      ntb = int'(mem(nta));
      atb = int'(mem(ata));
      plo = ((ct >> 4) & 1) * 4096 + ntb * 16 + row % 8;
      exp_addr.push_back(nta); exp_addr.push_back(ata);
      exp_addr.push_back(plo); exp_addr.push_back(plo + 8);
      t.lo = int'(mem(plo)); t.hi = int'(mem(plo + 8)); t.idx = i;
      t.pal = (atb >> (((row / 16) % 2) * 4 + ((col / 16) % 2) * 2)) & 3;
      exp_tiles.push_back(t);
    end
  endtask

  // Memory and loader responder, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.vram_rd_ack = 1'b0; bus.tile_ready = 1'b0; ack_wait = 0;
    end else begin
      bus.vram_rd_ack  = 1'b0;
      bus.vram_rd_data = 8'($urandom);
      if (bus.vram_rd_req) begin
        if (ack_wait == 0) begin
          bus.vram_rd_ack  = 1'b1;
          bus.vram_rd_data = mem(int'(bus.vram_addr));
          ack_wait = $urandom_range(0, max_delay);
        end else ack_wait--;
      end
      bus.tile_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Single compare process, on the falling edge.
  always @(negedge clk) begin
    bit was_active;
    if (!rst_n) begin
      chk("rst_req", bus.vram_rd_req, 0);     chk("rst_addr", bus.vram_addr, 0);
      chk("rst_valid", bus.tile_valid, 0);    chk("rst_pt", {bus.tile_pt_lo, bus.tile_pt_hi}, 0);
      chk("rst_pal_idx", {bus.tile_palette, bus.tile_index}, 0);
      chk("rst_status", {busy, line_done, overrun}, 0);
      active = 0; done_due = 0; exp_addr.delete(); exp_tiles.delete();
      prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0;
    end else begin
      was_active = active;
      chk("busy", busy, active && !done_due);
      chk("line_done", line_done, done_due);
      chk("overrun", overrun, line_start && was_active);
      if (done_due) begin
        active = 0; done_due = 0; lines_done++;
      end else if (line_start && !was_active) begin
        build_line(int'(line_row), int'(scroll), int'(ctrl));
        active = 1; seen_addr.delete(); tiles_seen = 0;
      end
      if (bus.vram_rd_req) begin
        if (exp_addr.size() == 0) chk("req_unexpected", bus.vram_rd_req, 0);
        else chk("vram_addr", bus.vram_addr, exp_addr[0]);
        if (prev_req && !prev_ack) chk("addr_stable", bus.vram_addr, prev_addr);
        if (bus.vram_rd_ack) begin
          seen_addr.push_back(int'(bus.vram_addr));
          if (exp_addr.size() > 0) void'(exp_addr.pop_front());
        end
      end else if (prev_req && !prev_ack) chk("req_held", bus.vram_rd_req, 1);
      if (bus.tile_valid) begin
        chk("req_in_push", bus.vram_rd_req, 0);
        if (exp_tiles.size() == 0) chk("tile_unexpected", bus.tile_valid, 0);
        else begin
          chk("tile_pt_lo", bus.tile_pt_lo, exp_tiles[0].lo);
          chk("tile_pt_hi", bus.tile_pt_hi, exp_tiles[0].hi);
          chk("tile_palette", bus.tile_palette, exp_tiles[0].pal);
          chk("tile_index", bus.tile_index, exp_tiles[0].idx);
        end
        if (prev_valid && !prev_ready)
          chk("tile_stable", {bus.tile_pt_lo, bus.tile_pt_hi, bus.tile_palette, bus.tile_index}, prev_bundle);
        if (bus.tile_ready) begin
          if (tiles_seen == 0) first_pal = int'(bus.tile_palette);
          tiles_seen++;
          if (exp_tiles.size() > 0) void'(exp_tiles.pop_front());
          if (exp_tiles.size() == 0) done_due = 1;
        end
      end else if (prev_valid && !prev_ready) chk("valid_held", bus.tile_valid, 1);
      prev_req = bus.vram_rd_req; prev_ack = bus.vram_rd_ack; prev_addr = bus.vram_addr;
      prev_valid = bus.tile_valid; prev_ready = bus.tile_ready;
      prev_bundle = {bus.tile_pt_lo, bus.tile_pt_hi, bus.tile_palette, bus.tile_index};
    end
  end

  // Start a line, scramble the inputs afterwards (they must be latched),
  // optionally inject a line_start ovr_at cycles in, wait for line_done.
  task automatic run_line(input int row, input int sc, input int ct, input int ovr_at, output int cyc);
    int base;
    @(posedge clk); #1;
    line_row = 9'(row); scroll = 16'(sc); ctrl = 8'(ct); line_start = 1'b1;
    base = lines_done;
    @(posedge clk); #1;
    line_start = 1'b0;
    line_row = 9'($urandom_range(0, 239)); scroll = 16'($urandom); ctrl = 8'($urandom);
    cyc = 0;
    while (lines_done == base && cyc < 6000) begin
      @(negedge clk); #1; cyc++;
      if (lines_done != base) break;
      @(posedge clk); #1;
      line_start = (ovr_at != 0 && cyc == ovr_at);
      if (line_start) begin
        line_row = 9'($urandom_range(0, 239)); scroll = 16'($urandom); ctrl = 8'($urandom);
      end
    end
    line_start = 1'b0;
    if (cyc >= 6000) chk("line_timeout", cyc, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; line_start = 1'b0; line_row = '0; scroll = '0; ctrl = '0;
    bus.vram_rd_ack = 1'b0; bus.vram_rd_data = '0; bus.tile_ready = 1'b0;
    force_mem = 1; max_delay = 0; stall_pct = 0; ack_wait = 0; lines_done = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait baseline; extra line_start lands in the DONE cycle.
    run_line(0, 'h0000, 'h00, 165, cyc);
    chk("A_cycles", cyc, 166);
    chk("A_nt", seen_at(0), 'h2000); chk("A_at", seen_at(1), 'h23C0);
    chk("A_plo", seen_at(2), 'h0410); chk("A_phi", seen_at(3), 'h0418);
    chk("A_tiles", tiles_seen, 33);   chk("A_pal", first_pal, 0);

    run_line(0, 'h0000, 'h10, 40, cyc);
    chk("B_plo", seen_at(2), 'h1410); chk("B_phi", seen_at(3), 'h1418);
    chk("B_cycles", cyc, 166);

    run_line(0, 'h00F8, 'h00, 0, cyc);
    chk("C_nt0", seen_at(0), 'h201F); chk("C_nt1", seen_at(4), 'h2400);
    chk("C_tiles", tiles_seen, 33);

    run_line(239, 'h0100, 'h00, 0, cyc);
    chk("D_nt", seen_at(0), 'h2800);

    run_line(1, 'hEF00, 'h02, 0, cyc);
    chk("E_nt", seen_at(0), 'h2040); chk("E_pal", first_pal, 2);

    // Random lines with ack delays and loader stalls.
    force_mem = 0; max_delay = 5; stall_pct = 30;
    for (int i = 0; i < 10; i++) begin
      run_line($urandom_range(0, 239), $urandom_range(0, 65535), $urandom_range(0, 255),
               (i % 2 == 0) ? $urandom_range(1, 150) : 0, cyc);
      chk("R_tiles", tiles_seen, 33);
      chk("R_reads", seen_addr.size(), 132);
    end

    // Reset in the middle of a line.
    @(posedge clk); #1;
    line_row = 9'd100; scroll = 16'h1234; ctrl = 8'h14; line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", bus.vram_rd_req, 0); chk("rst_mid_addr", bus.vram_addr, 0);
    chk("rst_mid_valid", bus.tile_valid, 0); chk("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    force_mem = 1; max_delay = 0; stall_pct = 0;
    run_line(0, 'h0000, 'h00, 0, cyc);
    chk("post_rst_nt", seen_at(0), 'h2000);
    chk("post_rst_cycles", cyc, 166);
    chk("post_rst_tiles", tiles_seen, 33);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bg_tile_fetch_sequencer.md
# bg_tile_fetch_sequencer

Per-scanline background tile fetch controller for the PPU. On each line start it walks 33 tile columns across the scrolled nametable space. For each tile it sequences four VRAM reads over a shared req/ack port: nametable byte, attribute byte, pattern low plane, pattern high plane. Each assembled tile is handed to the background shift-register loader over a valid/ready interface.

## Interface
- `TILES_PER_LINE`, default 33: tiles fetched per line (32 visible + 1 for fine-X scroll).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse; begin fetching a line.
- `line_row`  in  9  screen scanline, 0–239, sampled with `line_start`.
- `cpu_scroll_addr`  in  16  [15:8] scroll Y, [7:0] scroll X; sampled with `line_start`.
- `ppu_ctrl1`  in  8  bit1 = Y nametable bit, bit2 = X nametable bit, bit4 = background pattern table; sampled with `line_start`.
- `vram_rd_req`  out  1  read request.
- `vram_addr`  out  16  read address, stable while `vram_rd_req` is high.
- `vram_rd_ack`  in  1  read done; data is valid in the same cycle.
- `vram_rd_data`  in  8  read data.
- `tile_valid`  out  1  tile bundle is available.
- `tile_ready`  in  1  loader accepts the bundle.
- `tile_pt_lo`, `tile_pt_hi`  out  8  pattern planes.
- `tile_palette`  out  2  attribute palette select.
- `tile_index`  out  6  column position, 0 to `TILES_PER_LINE`-1.
- `busy`  out  1  high from the accepted `line_start` until `line_done`.
- `line_done`  out  1  one-cycle pulse after the last tile handshake.
- `overrun`  out  1  one-cycle pulse when `line_start` arrives while busy.

## Operation
- FSM states: IDLE → NT → AT → PLO → PHI → PUSH. From PUSH, go to NT if more tiles remain, otherwise to DONE. DONE → IDLE.
- Address states (NT, AT, PLO, PHI):
  - Assert `vram_rd_req` and drive the address.
  - Capture `vram_rd_data` on the edge where `req && ack`, then advance.
  - Never drop `req` or change the address before ack.
- Row computation, latched at `line_start`, 10-bit arithmetic:
  - `rs = line_row + {ctrl1[1], scroll_y}`; if `rs ≥ 480`, subtract 480.
  - `nt_v = (rs ≥ 240)`; `row = rs − (nt_v ? 240 : 0)`.
  - `fine_y = row[2:0]`.
- Column computation, per tile, 9-bit with natural wrap at 512: `col = tile_index*8 + {ctrl1[2], scroll_x}`; `nt_h = col[8]`.
- Addresses:
  - `nt_sel = {nt_v, nt_h}`.
  - NT: `0x2000 | nt_sel<<10 | row[7:3]<<5 | col[7:3]`.
  - AT: `0x23C0 | nt_sel<<10 | row[7:5]<<3 | col[7:5]`.
  - PLO: `ctrl1[4]<<12 | nt_byte<<4 | fine_y`.
  - PHI: PLO + 8.
- Palette: `(at_byte >> {row[4], col[4], 1'b0}) & 2'b11`.
- PUSH: hold `tile_valid` and all tile outputs constant until `tile_valid && tile_ready`, then increment `tile_index`.
- `line_start` while busy: ignored and `overrun` pulses. Latched scroll and ctrl values are not changed.
- `line_start` in the cycle `line_done` pulses counts as busy and is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `tile_index` = 0.
- `line_start` in cycle N → `vram_rd_req` high with the NT address in cycle N+1.
- Each access takes one cycle when ack arrives the same cycle; `vram_addr` is registered.
- Tile throughput with zero-wait ack and ready tied high: 5 cycles per tile (4 reads + PUSH). A full line takes 165 cycles plus 1 DONE cycle.
- `line_done` pulses in the cycle after the final handshake; `busy` falls in that same cycle.
- Async reset mid-line: everything returns immediately to the reset values. No partial tile is emitted afterwards.

## Structure
- Shared package `ppu_pkg` holds:
  - nametable base 0x2000 and attribute offset 0x3C0;
  - `NT_ROWS` = 30 and `LINE_ROWS` = 240;
  - the FSM state enum;
  - a tile bundle struct (`pt_lo`, `pt_hi`, `palette`, `index`).
- One natural sub-module, `bg_addr_gen`: combinational; takes latched row/scroll/ctrl, `tile_index`, and `nt_byte`; returns the NT, AT and PLO addresses and the attribute shift. The top holds the FSM, counters and registers.

## Test plan
- Scroll 0, ctrl 0, `line_row` 0, `nt_byte` = 0x41 → first addresses 0x2000, 0x23C0, 0x0410, 0x0418; `tile_index` 0; 165 cycles to `line_done` with zero-wait ack and ready high.
- Same as above with ctrl1 = 0x10 → pattern addresses 0x1410 and 0x1418.
- scroll_x = 0xF8, ctrl1[2] = 0 → tile 0 NT address 0x201F, tile 1 NT address 0x2400; 33 tiles emitted in total.
- `line_row` 239, scroll_y 1 → row 240 wraps to nametable 2 → first NT address 0x2800. `line_row` 1, scroll_y 0xEF, ctrl1[1] = 1 → rs 496 − 480 = 16 → NT address 0x2040.
- Attribute byte 0xE4, row[4] = 1, col[4] = 0 → `tile_palette` = 2. With random ack delays of 0–5 cycles and `tile_ready` stalls, `req`, address and tile outputs stay stable until their handshakes.
- `line_start` mid-line → `overrun` pulses, nothing else changes. `rst_n` low mid-access → all outputs 0 at once; a new line after reset starts at 0x2000.
